// File: rtl/icb_arbiter_2to1_if.sv
// ---------------------------------------------------------------------------
// icb_arbiter_2to1_if
//   One ICB link: command channel (addr/read/wdata/wmask/valid/ready) and
//   response channel (rdata/err/valid/ready).
//   modport master : drives the command, accepts the response.
//   modport slave  : accepts the command, drives the response.
// ---------------------------------------------------------------------------
interface icb_arbiter_2to1_if;
   logic [31:0] icb_cmd_addr;
   logic        icb_cmd_read;
   logic [31:0] icb_cmd_wdata;
   logic [3:0]  icb_cmd_wmask;
   logic        icb_cmd_valid;
   logic        icb_cmd_ready;
   logic [31:0] icb_rsp_rdata;
   logic        icb_rsp_err;
   logic        icb_rsp_valid;
   logic        icb_rsp_ready;

   modport master (
      output icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_cmd_valid,
      input  icb_cmd_ready,
      input  icb_rsp_rdata, icb_rsp_err, icb_rsp_valid,
      output icb_rsp_ready
   );

   modport slave (
      input  icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_cmd_valid,
      output icb_cmd_ready,
      output icb_rsp_rdata, icb_rsp_err, icb_rsp_valid,
      input  icb_rsp_ready
   );
endinterface

// File: rtl/icb_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// icb_arbiter_2to1
//   Shares one ICB slave (SRAM controller) between instruction fetch (s0)
//   and data access (s1). Command channel is arbitrated combinationally,
//   the issuing master ID of each accepted command is queued in a small
//   ID FIFO, and in-order responses are routed back using the FIFO head.
//   When the FIFO is empty a same-cycle response is routed to the current
//   grant (slaves with immediate write response).
//
//   Optional feature macro: ICB_ARB_ROUND_ROBIN_EN
//     defined   : simultaneous requests alternate (round-robin on last_grant)
//     undefined : s0 always wins simultaneous requests
//
// Ports
//   s_icb_aclk     clock
//   s_icb_aresetn  asynchronous active-low reset
//   s0, s1         upstream masters (slave modport of the ICB link)
//   m              downstream SRAM slave (master modport of the ICB link)
// Parameters
//   outstanding_depth  max accepted-but-unresponded commands (2,4,8)
//   simulation_delay   kept for compatibility with simulation models
// ---------------------------------------------------------------------------
module icb_arbiter_2to1 #(
   parameter int outstanding_depth = 4,
   parameter int simulation_delay  = 1
) (
   input  logic                      s_icb_aclk,
   input  logic                      s_icb_aresetn,
   icb_arbiter_2to1_if.slave         s0,
   icb_arbiter_2to1_if.slave         s1,
   icb_arbiter_2to1_if.master        m
);

   localparam int PTR_W = $clog2(outstanding_depth);
   localparam int CNT_W = PTR_W + 1;

   // Registers here always update at the clock edge; the delay is not modelled.
   localparam int unused_sim_delay = simulation_delay;

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             lock_q, lock_d;
   logic             lock_id_q, lock_id_d;
   logic             last_grant_q, last_grant_d;
   logic             fifo_mem_q [outstanding_depth];

   logic grant;
   logic both_pick;
   logic gnt_valid;
   logic fifo_full;
   logic fifo_empty;
   logic cmd_hs;
   logic rsp_hs;
   logic push;
   logic pop;
   logic rsp_target;

`ifdef ICB_ARB_ROUND_ROBIN_EN
   assign both_pick = ~last_grant_q;
`else
   // Fixed priority: last_grant is still tracked but does not steer grant.
   logic unused_last_grant;
   assign unused_last_grant = last_grant_q;
   assign both_pick         = 1'b0;
`endif

   always_comb begin
      grant = 1'b0;
      if (lock_q)
         grant = lock_id_q;
      else if (s0.icb_cmd_valid && s1.icb_cmd_valid)
         grant = both_pick;
      else if (s1.icb_cmd_valid)
         grant = 1'b1;
   end

   assign fifo_full  = (count_q == CNT_W'(outstanding_depth));
   assign fifo_empty = (count_q == '0);
   assign gnt_valid  = grant ? s1.icb_cmd_valid : s0.icb_cmd_valid;

   // Command path
   assign m.icb_cmd_valid = gnt_valid & ~fifo_full;
   assign m.icb_cmd_addr  = grant ? s1.icb_cmd_addr  : s0.icb_cmd_addr;
   assign m.icb_cmd_read  = grant ? s1.icb_cmd_read  : s0.icb_cmd_read;
   assign m.icb_cmd_wdata = grant ? s1.icb_cmd_wdata : s0.icb_cmd_wdata;
   assign m.icb_cmd_wmask = grant ? s1.icb_cmd_wmask : s0.icb_cmd_wmask;
   assign s0.icb_cmd_ready = ~grant & m.icb_cmd_ready & ~fifo_full;
   assign s1.icb_cmd_ready =  grant & m.icb_cmd_ready & ~fifo_full;

   // Response path: empty FIFO means the response belongs to the command
   // being handed over in this very cycle.
   assign rsp_target       = fifo_empty ? grant : fifo_mem_q[rd_ptr_q];
   assign s0.icb_rsp_valid = ~rsp_target & m.icb_rsp_valid;
   assign s1.icb_rsp_valid =  rsp_target & m.icb_rsp_valid;
   assign s0.icb_rsp_rdata = m.icb_rsp_rdata;
   assign s1.icb_rsp_rdata = m.icb_rsp_rdata;
   assign s0.icb_rsp_err   = m.icb_rsp_err;
   assign s1.icb_rsp_err   = m.icb_rsp_err;
   assign m.icb_rsp_ready  = rsp_target ? s1.icb_rsp_ready : s0.icb_rsp_ready;

   assign cmd_hs = m.icb_cmd_valid & m.icb_cmd_ready;
   assign rsp_hs = m.icb_rsp_valid & m.icb_rsp_ready;
   // A bypassed transfer (empty FIFO, cmd and rsp together) never enters the FIFO.
   assign push   = cmd_hs & ~(fifo_empty & rsp_hs);
   assign pop    = rsp_hs & ~fifo_empty;

   always_comb begin
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      lock_d       = lock_q;
      lock_id_d    = lock_id_q;
      last_grant_d = last_grant_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Hold the grant while the slave stalls so its command fields stay stable.
      if (cmd_hs) begin
         lock_d       = 1'b0;
         last_grant_d = grant;
      end else if (m.icb_cmd_valid && !m.icb_cmd_ready) begin
         lock_d    = 1'b1;
         lock_id_d = grant;
      end
   end

   always_ff @(posedge s_icb_aclk or negedge s_icb_aresetn) begin
      if (!s_icb_aresetn) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         lock_q       <= 1'b0;
         lock_id_q    <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         lock_q       <= lock_d;
         lock_id_q    <= lock_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   // ID storage needs no reset: entries are only read while count is non-zero.
   always_ff @(posedge s_icb_aclk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= grant;
   end

endmodule

// File: tb/tb_icb_arbiter_2to1.sv
module tb_icb_arbiter_2to1;
   logic clk;
   logic aresetn;
   int   n_cmp;
   int   n_err;
   logic prev_g;
   logic exp_g;

   icb_arbiter_2to1_if s0_if();
   icb_arbiter_2to1_if s1_if();
   icb_arbiter_2to1_if m_if();

   icb_arbiter_2to1 #(.outstanding_depth(4), .simulation_delay(1)) dut (
      .s_icb_aclk    (clk),
      .s_icb_aresetn (aresetn),
      .s0            (s0_if),
      .s1            (s1_if),
      .m             (m_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      s0_if.icb_cmd_valid = 0; s0_if.icb_cmd_addr = 0; s0_if.icb_cmd_read = 0;
      s0_if.icb_cmd_wdata = 0; s0_if.icb_cmd_wmask = 0; s0_if.icb_rsp_ready = 0;
      s1_if.icb_cmd_valid = 0; s1_if.icb_cmd_addr = 0; s1_if.icb_cmd_read = 0;
      s1_if.icb_cmd_wdata = 0; s1_if.icb_cmd_wmask = 0; s1_if.icb_rsp_ready = 0;
      m_if.icb_cmd_ready = 0; m_if.icb_rsp_valid = 0; m_if.icb_rsp_rdata = 0;
      m_if.icb_rsp_err = 0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      prev_g = 0;
      exp_g = 0;
      aresetn = 0;
      idle();
      tick();
      tick();
      // Reset state
      chk("rst_count", 32'(dut.count_q), 0);
      chk("rst_last_grant", 32'(dut.last_grant_q), 1);
      chk("rst_m_valid", 32'(m_if.icb_cmd_valid), 0);
      aresetn = 1;
      #1;
      chk("idle_s0_ready", 32'(s0_if.icb_cmd_ready), 0);
      chk("idle_s1_ready", 32'(s1_if.icb_cmd_ready), 0);
      chk("idle_s0_rsp", 32'(s0_if.icb_rsp_valid), 0);
      chk("idle_s1_rsp", 32'(s1_if.icb_rsp_valid), 0);
      chk("idle_m_rsp_ready", 32'(m_if.icb_rsp_ready), 0);
      tick();

      // Single master read from s1
      s1_if.icb_cmd_valid = 1; s1_if.icb_cmd_read = 1; s1_if.icb_cmd_addr = 32'h100;
      m_if.icb_cmd_ready = 1;
      #1;
      chk("t1_m_valid", 32'(m_if.icb_cmd_valid), 1);
      chk("t1_m_addr", m_if.icb_cmd_addr, 32'h100);
      chk("t1_m_read", 32'(m_if.icb_cmd_read), 1);
      chk("t1_s1_ready", 32'(s1_if.icb_cmd_ready), 1);
      chk("t1_s0_ready", 32'(s0_if.icb_cmd_ready), 0);
      tick();
      chk("t1_count1", 32'(dut.count_q), 1);
      idle();
      m_if.icb_rsp_valid = 1; m_if.icb_rsp_rdata = 32'hDEADBEEF; s1_if.icb_rsp_ready = 1;
      #1;
      chk("t1_s1_rsp", 32'(s1_if.icb_rsp_valid), 1);
      chk("t1_s0_rsp", 32'(s0_if.icb_rsp_valid), 0);
      chk("t1_s1_rdata", s1_if.icb_rsp_rdata, 32'hDEADBEEF);
      chk("t1_m_rsp_ready", 32'(m_if.icb_rsp_ready), 1);
      tick();
      chk("t1_count0", 32'(dut.count_q), 0);
      idle();

      // Both masters request every cycle, slave ready, responses one cycle later
      for (int i = 0; i < 4; i++) begin
         s0_if.icb_cmd_valid = 1; s0_if.icb_cmd_addr = 32'h1000 + i;
         s1_if.icb_cmd_valid = 1; s1_if.icb_cmd_addr = 32'h2000 + i;
         s0_if.icb_rsp_ready = 1; s1_if.icb_rsp_ready = 1;
         m_if.icb_cmd_ready = 1;
         m_if.icb_rsp_valid = (i > 0);
         m_if.icb_rsp_rdata = 32'hA000_0000 + i;
         #1;
`ifdef ICB_ARB_ROUND_ROBIN_EN
         exp_g = i[0];
`else
         exp_g = 1'b0;
`endif
         chk("rr_addr", m_if.icb_cmd_addr, exp_g ? 32'h2000 + i : 32'h1000 + i);
         chk("rr_s0_ready", 32'(s0_if.icb_cmd_ready), 32'(!exp_g));
         chk("rr_s1_ready", 32'(s1_if.icb_cmd_ready), 32'(exp_g));
         if (i > 0) begin
            chk("rr_rsp_s0", 32'(s0_if.icb_rsp_valid), 32'(prev_g == 1'b0));
            chk("rr_rsp_s1", 32'(s1_if.icb_rsp_valid), 32'(prev_g == 1'b1));
         end
         prev_g = exp_g;
         tick();
      end
      s0_if.icb_cmd_valid = 0; s1_if.icb_cmd_valid = 0;
      m_if.icb_rsp_valid = 1; m_if.icb_rsp_rdata = 32'hA000_0004;
      #1;
      chk("rr_last_rsp_s0", 32'(s0_if.icb_rsp_valid), 32'(prev_g == 1'b0));
      chk("rr_last_rsp_s1", 32'(s1_if.icb_rsp_valid), 32'(prev_g == 1'b1));
      tick();
      chk("rr_count0", 32'(dut.count_q), 0);
      idle();

      // Slave stalls: grant locked to s1 even after s0 raises valid
      s1_if.icb_cmd_valid = 1; s1_if.icb_cmd_read = 1; s1_if.icb_cmd_addr = 32'h300;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("lk_hold_addr", m_if.icb_cmd_addr, 32'h300);
         chk("lk_hold_valid", 32'(m_if.icb_cmd_valid), 1);
         chk("lk_hold_s1_ready", 32'(s1_if.icb_cmd_ready), 0);
         tick();
      end
      s0_if.icb_cmd_valid = 1; s0_if.icb_cmd_addr = 32'h400;
      m_if.icb_cmd_ready = 1;
      #1;
      chk("lk_addr", m_if.icb_cmd_addr, 32'h300);
      chk("lk_s1_ready", 32'(s1_if.icb_cmd_ready), 1);
      chk("lk_s0_ready", 32'(s0_if.icb_cmd_ready), 0);
      tick();
      s1_if.icb_cmd_valid = 0;
      #1;
      chk("lk_after_addr", m_if.icb_cmd_addr, 32'h400);
      chk("lk_after_s0_ready", 32'(s0_if.icb_cmd_ready), 1);
      tick();
      chk("lk_count2", 32'(dut.count_q), 2);
      s0_if.icb_cmd_valid = 0;
      s0_if.icb_rsp_ready = 1; s1_if.icb_rsp_ready = 1;
      m_if.icb_rsp_valid = 1; m_if.icb_rsp_rdata = 32'h11;
      #1;
      chk("lk_rsp1_s1", 32'(s1_if.icb_rsp_valid), 1);
      chk("lk_rsp1_s0", 32'(s0_if.icb_rsp_valid), 0);
      tick();
      m_if.icb_rsp_rdata = 32'h22;
      #1;
      chk("lk_rsp2_s0", 32'(s0_if.icb_rsp_valid), 1);
      chk("lk_rsp2_s1", 32'(s1_if.icb_rsp_valid), 0);
      chk("lk_rsp2_rdata", s0_if.icb_rsp_rdata, 32'h22);
      tick();
      chk("lk_count0", 32'(dut.count_q), 0);
      idle();

      // Immediate write response with empty FIFO
      s1_if.icb_cmd_valid = 1; s1_if.icb_cmd_read = 0; s1_if.icb_cmd_addr = 32'h600;
      s1_if.icb_cmd_wdata = 32'hCAFE0001; s1_if.icb_cmd_wmask = 4'hF;
      s1_if.icb_rsp_ready = 1;
      m_if.icb_cmd_ready = 1; m_if.icb_rsp_valid = 1;
      #1;
      chk("imm_wdata", m_if.icb_cmd_wdata, 32'hCAFE0001);
      chk("imm_s1_rsp", 32'(s1_if.icb_rsp_valid), 1);
      chk("imm_s0_rsp", 32'(s0_if.icb_rsp_valid), 0);
      chk("imm_m_rsp_ready", 32'(m_if.icb_rsp_ready), 1);
      tick();
      chk("imm_count0", 32'(dut.count_q), 0);
      idle();

      // FIFO full: four accepted, fifth blocked, one response unblocks next cycle
      s0_if.icb_cmd_valid = 1; s0_if.icb_cmd_addr = 32'h700;
      m_if.icb_cmd_ready = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("full_accept", 32'(s0_if.icb_cmd_ready), 1);
         tick();
      end
      #1;
      chk("full_s0_ready", 32'(s0_if.icb_cmd_ready), 0);
      chk("full_m_valid", 32'(m_if.icb_cmd_valid), 0);
      chk("full_count4", 32'(dut.count_q), 4);
      tick();
      chk("full_no_lock", 32'(dut.lock_q), 0);
      m_if.icb_rsp_valid = 1; s0_if.icb_rsp_ready = 1;
      #1;
      chk("full_pop_s0_ready", 32'(s0_if.icb_cmd_ready), 0);
      chk("full_pop_s0_rsp", 32'(s0_if.icb_rsp_valid), 1);
      tick();
      m_if.icb_rsp_valid = 0;
      #1;
      chk("full_resume", 32'(s0_if.icb_cmd_ready), 1);
      tick();
      chk("full_count4b", 32'(dut.count_q), 4);
      s0_if.icb_cmd_valid = 0;
      m_if.icb_rsp_valid = 1;
      tick();
      m_if.icb_rsp_valid = 0;
      chk("pre_rst_count3", 32'(dut.count_q), 3);

      // Asynchronous reset mid-cycle with 3 outstanding
      aresetn = 0;
      #1;
      chk("arst_count", 32'(dut.count_q), 0);
      chk("arst_s0_rsp", 32'(s0_if.icb_rsp_valid), 0);
      chk("arst_s1_rsp", 32'(s1_if.icb_rsp_valid), 0);
      #2;
      aresetn = 1;
      s0_if.icb_cmd_valid = 1; s0_if.icb_cmd_addr = 32'h500;
      m_if.icb_cmd_ready = 1;
      #1;
      chk("post_rst_valid", 32'(m_if.icb_cmd_valid), 1);
      chk("post_rst_addr", m_if.icb_cmd_addr, 32'h500);
      chk("post_rst_s0_ready", 32'(s0_if.icb_cmd_ready), 1);
      tick();
      chk("post_rst_count1", 32'(dut.count_q), 1);
      idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
